// File: rtl/vga_pkg.sv
// Shared video/game constants and the boss hit-detect state type.
package vga_pkg;

    localparam int unsigned COORD_W           = 12;
    localparam int unsigned BOUND_W           = COORD_W + 1;
    localparam int unsigned MELEE_RANGE_DEF   = 40;
    localparam int unsigned IFRAME_FRAMES_DEF = 8;
    localparam logic [1:0]  ACTIVE_STATE_DEF  = 2'd1;

    typedef enum logic {
        READY    = 1'b0,
        COOLDOWN = 1'b1
    } boss_hit_state_t;

    // a - b in 13-bit signed math, negative results clamp to 0
    function automatic logic [BOUND_W-1:0] sub_clamp(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        logic signed [BOUND_W-1:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return diff[BOUND_W-1] ? '0 : $unsigned(diff);
    endfunction

    function automatic logic [BOUND_W-1:0] add_ext(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/boss_hit_detect_contains.sv
// Combinational test of a horizontal span at height pt_y against a centre/half-size box.
module hitbox_contains
    import vga_pkg::*;
(
    input  logic [COORD_W-1:0] box_x_i,
    input  logic [COORD_W-1:0] box_y_i,
    input  logic [COORD_W-1:0] box_lng_i,
    input  logic [COORD_W-1:0] box_hgt_i,
    input  logic [BOUND_W-1:0] span_lo_i,
    input  logic [BOUND_W-1:0] span_hi_i,
    input  logic [COORD_W-1:0] pt_y_i,
    output logic               inside_c_o
);

    logic [BOUND_W-1:0] left_c, right_c, top_c, bottom_c, pt_y_ext_c;

    always_comb begin
        left_c     = sub_clamp(box_x_i, box_lng_i);
        right_c    = add_ext(box_x_i, box_lng_i);
        top_c      = sub_clamp(box_y_i, box_hgt_i);
        bottom_c   = add_ext(box_y_i, box_hgt_i);
        pt_y_ext_c = {1'b0, pt_y_i};
        // inclusive overlap of [span_lo, span_hi] with [left, right]; a point uses lo == hi
        inside_c_o = (span_hi_i >= left_c) && (span_lo_i <= right_c) &&
                     (pt_y_ext_c >= top_c) && (pt_y_ext_c <= bottom_c);
    end

endmodule

// File: rtl/boss_hit_detect.sv
// Boss hit detection: two-stage pipeline producing damage/consume pulses with i-frames
// and one-hit-per-swing.
module boss_hit_detect
    import vga_pkg::*;
#(
    parameter int unsigned IFRAME_FRAMES = IFRAME_FRAMES_DEF,
    parameter int unsigned MELEE_RANGE   = MELEE_RANGE_DEF,
    parameter logic [1:0]  ACTIVE_STATE  = ACTIVE_STATE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_active,
    input  logic        game_start,
    input  logic        frame_tick,
    input  logic        boss_alive,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic [11:0] boss_lng,
    input  logic [11:0] boss_hgt,
    input  logic [11:0] proj_x,
    input  logic [11:0] proj_y,
    input  logic        proj_active,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic        char_dir,
    input  logic        melee_active,
    output logic        projectile_hit,
    output logic        melee_hit,
    output logic        proj_consume,
    output logic        boss_invuln
);

    localparam int unsigned CNT_W = (IFRAME_FRAMES > 1) ? $clog2(IFRAME_FRAMES + 1) : 1;

    logic [BOUND_W-1:0] proj_ext_c, melee_lo_c, melee_hi_c;
    logic               proj_in_c, melee_in_c;

    always_comb begin
        proj_ext_c = {1'b0, proj_x};
        if (char_dir) begin
            melee_lo_c = {1'b0, char_x};
            melee_hi_c = add_ext(char_x, COORD_W'(MELEE_RANGE));
        end else begin
            melee_lo_c = sub_clamp(char_x, COORD_W'(MELEE_RANGE));
            melee_hi_c = {1'b0, char_x};
        end
    end

    hitbox_contains u_proj_box (
        .box_x_i    (boss_x),
        .box_y_i    (boss_y),
        .box_lng_i  (boss_lng),
        .box_hgt_i  (boss_hgt),
        .span_lo_i  (proj_ext_c),
        .span_hi_i  (proj_ext_c),
        .pt_y_i     (proj_y),
        .inside_c_o (proj_in_c)
    );

    hitbox_contains u_melee_box (
        .box_x_i    (boss_x),
        .box_y_i    (boss_y),
        .box_lng_i  (boss_lng),
        .box_hgt_i  (boss_hgt),
        .span_lo_i  (melee_lo_c),
        .span_hi_i  (melee_hi_c),
        .pt_y_i     (char_y),
        .inside_c_o (melee_in_c)
    );

    // Stage 1: registered overlap flags plus swing level history aligned with them
    logic p_in_q, m_in_q, mact_q, mact_prev_q, p_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_in_q      <= 1'b0;
            m_in_q      <= 1'b0;
            mact_q      <= 1'b0;
            mact_prev_q <= 1'b0;
            p_prev_q    <= 1'b0;
        end else begin
            p_in_q      <= proj_active & proj_in_c;
            m_in_q      <= melee_active & melee_in_c;
            mact_q      <= melee_active;
            mact_prev_q <= mact_q;
            p_prev_q    <= p_in_q;
        end
    end

    logic eval_c, p_rise_c, m_new_c, m_fall_c;
    logic swing_used_q;

    always_comb begin
        eval_c   = (game_active == ACTIVE_STATE) & boss_alive;
        p_rise_c = p_in_q & ~p_prev_q;
        m_new_c  = m_in_q & ~swing_used_q;
        m_fall_c = mact_prev_q & ~mact_q;
    end

    // Stage 2: hit FSM with registered pulse outputs
    boss_hit_state_t  state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             proj_hit_q, melee_hit_q, consume_q, invuln_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= READY;
            cnt_q        <= '0;
            swing_used_q <= 1'b0;
            proj_hit_q   <= 1'b0;
            melee_hit_q  <= 1'b0;
            consume_q    <= 1'b0;
            invuln_q     <= 1'b0;
        end else begin
            proj_hit_q  <= 1'b0;
            melee_hit_q <= 1'b0;
            consume_q   <= 1'b0;
            // swing release tracks the input level even while evaluation is paused
            if (m_fall_c) begin
                swing_used_q <= 1'b0;
            end
            if (game_start) begin
                state_q      <= READY;
                cnt_q        <= '0;
                swing_used_q <= 1'b0;
                invuln_q     <= 1'b0;
            end else if (eval_c) begin
                case (state_q)
                    READY: begin
                        if (p_rise_c) begin
                            proj_hit_q <= 1'b1;
                            consume_q  <= 1'b1;
                        end
                        if (m_new_c) begin
                            melee_hit_q  <= 1'b1;
                            swing_used_q <= 1'b1;
                        end
                        if (p_rise_c | m_new_c) begin
                            state_q  <= COOLDOWN;
                            cnt_q    <= CNT_W'(IFRAME_FRAMES);
                            invuln_q <= 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        if (p_rise_c) begin
                            consume_q <= 1'b1;
                        end
                        if (cnt_q == '0) begin
                            state_q  <= READY;
                            invuln_q <= 1'b0;
                        end else if (frame_tick) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= READY;
                        invuln_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign projectile_hit = proj_hit_q;
    assign melee_hit      = melee_hit_q;
    assign proj_consume   = consume_q;
    assign boss_invuln    = invuln_q;

endmodule

// File: tb/tb_boss_hit_detect.sv
// Scoreboard bench for boss_hit_detect: directed vectors, expected pulses queued with their cycle.
module tb_boss_hit_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  game_active = 2'd1;
    logic        game_start = 1'b0;
    logic        frame_tick = 1'b0;
    logic        boss_alive = 1'b1;
    logic [11:0] boss_x = 12'd400, boss_y = 12'd300, boss_lng = 12'd50, boss_hgt = 12'd60;
    logic [11:0] proj_x = 12'd0, proj_y = 12'd0;
    logic        proj_active = 1'b0;
    logic [11:0] char_x = 12'd330, char_y = 12'd300;
    logic        char_dir = 1'b1;
    logic        melee_active = 1'b0;
    logic        projectile_hit, melee_hit, proj_consume, boss_invuln;

    boss_hit_detect dut (
        .clk            (clk),
        .rst            (rst),
        .game_active    (game_active),
        .game_start     (game_start),
        .frame_tick     (frame_tick),
        .boss_alive     (boss_alive),
        .boss_x         (boss_x),
        .boss_y         (boss_y),
        .boss_lng       (boss_lng),
        .boss_hgt       (boss_hgt),
        .proj_x         (proj_x),
        .proj_y         (proj_y),
        .proj_active    (proj_active),
        .char_x         (char_x),
        .char_y         (char_y),
        .char_dir       (char_dir),
        .melee_active   (melee_active),
        .projectile_hit (projectile_hit),
        .melee_hit      (melee_hit),
        .proj_consume   (proj_consume),
        .boss_invuln    (boss_invuln)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit ph;
        bit mh;
        bit pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int total = 0;
    int bad = 0;

    // Monitor: every cycle with any pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && (projectile_hit || melee_hit || proj_consume)) begin
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_pulse cyc=%0d got ph=%b mh=%b pc=%b required no pulse",
                         cyc, projectile_hit, melee_hit, proj_consume);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.ph != projectile_hit || e.mh != melee_hit ||
                    e.pc != proj_consume) begin
                    bad = bad + 1;
                    $display("FAIL pulse cyc=%0d ph=%b mh=%b pc=%b required cyc=%0d ph=%b mh=%b pc=%b",
                             cyc, projectile_hit, melee_hit, proj_consume, e.cyc, e.ph, e.mh, e.pc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // inputs driven now reach the outputs two edges later
    task automatic push_exp(input bit ph, input bit mh, input bit pc);
        exp_t x;
        x.cyc = cyc + 2;
        x.ph  = ph;
        x.mh  = mh;
        x.pc  = pc;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s got=%b required=%b", name, act, req);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic proj_pulse(input logic [11:0] x, input logic [11:0] y);
        proj_x = x;
        proj_y = y;
        proj_active = 1'b1;
        step(1);
        proj_active = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_ph", projectile_hit, 1'b0);
        chk("rst_mh", melee_hit, 1'b0);
        chk("rst_pc", proj_consume, 1'b0);
        chk("rst_inv", boss_invuln, 1'b0);
        rst = 1'b0;
        step(2);

        // 1: edge of box inclusive at (450,360), one past is outside
        proj_pulse(12'd451, 12'd360);
        step(4);
        push_exp(1, 0, 1);
        proj_pulse(12'd450, 12'd360);
        step(3);
        chk("t1_invuln", boss_invuln, 1'b1);
        frames(8);
        step(3);
        chk("t1_ready", boss_invuln, 1'b0);

        // 2: re-presented projectile during i-frames is absorbed once, then damage after 8 ticks
        push_exp(1, 0, 1);
        proj_pulse(12'd400, 12'd300);
        step(3);
        push_exp(0, 0, 1);
        proj_active = 1'b1;
        frames(3);
        proj_active = 1'b0;
        step(1);
        frames(4);
        chk("t2_invuln_7ticks", boss_invuln, 1'b1);
        frames(1);
        step(3);
        chk("t2_ready_8ticks", boss_invuln, 1'b0);
        push_exp(1, 0, 1);
        proj_pulse(12'd400, 12'd300);
        step(3);
        frames(8);
        step(3);

        // 3: one hit per swing even when the swing outlives the cooldown; left-facing misses
        char_x = 12'd330;
        char_y = 12'd300;
        char_dir = 1'b1;
        push_exp(0, 1, 0);
        melee_active = 1'b1;
        step(3);
        frames(8);
        step(10);
        chk("t3_ready_mid_swing", boss_invuln, 1'b0);
        melee_active = 1'b0;
        step(3);
        char_dir = 1'b0;
        melee_active = 1'b1;
        step(20);
        melee_active = 1'b0;
        step(3);
        char_dir = 1'b1;

        // 4: projectile and melee together share one cooldown
        proj_x = 12'd400;
        proj_y = 12'd300;
        push_exp(1, 1, 1);
        proj_active = 1'b1;
        melee_active = 1'b1;
        step(1);
        proj_active = 1'b0;
        step(2);
        melee_active = 1'b0;
        step(2);
        chk("t4_invuln", boss_invuln, 1'b1);
        frames(8);
        step(3);
        chk("t4_ready", boss_invuln, 1'b0);

        // 5: left bound clamps to 0; no evaluation while dead or out of the active state
        boss_x = 12'd20;
        push_exp(1, 0, 1);
        proj_pulse(12'd0, 12'd300);
        step(3);
        frames(8);
        step(3);
        boss_alive = 1'b0;
        proj_pulse(12'd0, 12'd300);
        step(4);
        chk("t5_dead_invuln", boss_invuln, 1'b0);
        boss_alive = 1'b1;
        game_active = 2'd2;
        proj_pulse(12'd0, 12'd300);
        step(4);
        chk("t5_inactive_invuln", boss_invuln, 1'b0);
        game_active = 2'd1;
        boss_x = 12'd400;
        step(2);

        // 6: game_start mid-cooldown, async reset mid-cooldown, game_start beats a same-cycle hit
        push_exp(1, 0, 1);
        proj_pulse(12'd400, 12'd300);
        step(3);
        frames(3);
        chk("t6_invuln_cnt5", boss_invuln, 1'b1);
        game_start = 1'b1;
        step(1);
        game_start = 1'b0;
        chk("t6_gs_invuln", boss_invuln, 1'b0);
        push_exp(1, 0, 1);
        proj_pulse(12'd400, 12'd300);
        step(3);
        chk("t6_rehit_invuln", boss_invuln, 1'b1);
        #2 rst = 1'b1;
        #1 chk("t6_async_rst_invuln", boss_invuln, 1'b0);
        step(2);
        rst = 1'b0;
        step(2);
        proj_active = 1'b1;
        step(1);
        proj_active = 1'b0;
        game_start = 1'b1;
        step(1);
        game_start = 1'b0;
        step(4);
        chk("t6_gs_priority_invuln", boss_invuln, 1'b0);

        step(5);
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL missing_pulses pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
